// File: rtl/tuner_phy_pkg.sv
// Shared types for the tuner PHY control arbiter: FSM states and channel ids.
package tuner_phy_pkg;

  typedef enum logic [1:0] {
    ARB_CTRL_INIT   = 2'd0,
    ARB_CTRL_TUNE   = 2'd1,
    ARB_CTRL_SYNC   = 2'd2,
    ARB_CTRL_COMMIT = 2'd3
  } tuner_phy_ctrl_arb_state_e;

  typedef enum logic {
    CH_SEARCH = 1'b0,
    CH_LOCK   = 1'b1
  } tuner_ctrl_ch_e;

  localparam int unsigned NUM_CH = 2;

  function automatic tuner_ctrl_ch_e other_ch(input tuner_ctrl_ch_e ch);
    return (ch == CH_SEARCH) ? CH_LOCK : CH_SEARCH;
  endfunction

endpackage

// File: rtl/tuner_phy_ctrl_rr_arb.sv
// Two-way grant: fixed LOCK priority, or round-robin starting from i_ptr.
module tuner_phy_ctrl_rr_arb
  import tuner_phy_pkg::*;
#(
  parameter bit LOCK_PRIO = 1'b1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  tuner_ctrl_ch_e    i_ptr,
  output logic [NUM_CH-1:0] o_gnt,
  output tuner_ctrl_ch_e    o_gnt_ch
);

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    o_gnt_ch = CH_SEARCH;
    if (LOCK_PRIO) begin
      o_gnt_ch = i_req[CH_LOCK] ? CH_LOCK : CH_SEARCH;
    end else begin
      o_gnt_ch = i_req[i_ptr] ? i_ptr : other_ch(i_ptr);
    end
    o_gnt = (i_req != '0) ? (NUM_CH'(1) << o_gnt_ch) : '0;
  end

endmodule

// File: rtl/tuner_phy_ctrl_arbiter.sv
// Shares one tuner DAC / power-detect port between SEARCH and LOCK channels,
// sequencing INIT -> TUNE -> SYNC -> COMMIT for each granted request.
module tuner_phy_ctrl_arbiter
  import tuner_phy_pkg::*;
#(
  parameter int unsigned CODE_W    = 8,
  parameter int unsigned PWR_W     = 12,
  parameter int unsigned CNT_W     = 16,
  parameter bit          LOCK_PRIO = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             i_req_valid,
  output logic [NUM_CH-1:0]             o_req_ready,
  input  logic [NUM_CH-1:0][CODE_W-1:0] i_req_code,
  input  logic [CODE_W-1:0]             i_code_max,
  input  logic [CNT_W-1:0]              i_settle_cyc,
  input  logic [CNT_W-1:0]              i_timeout_cyc,
  output logic [CODE_W-1:0]             o_tune_code,
  output logic                          o_tune_valid,
  output logic                          o_pwr_req,
  input  logic                          i_pwr_valid,
  input  logic [PWR_W-1:0]              i_pwr,
  output logic [NUM_CH-1:0]             o_rsp_valid,
  output logic [CODE_W-1:0]             o_rsp_code,
  output logic [PWR_W-1:0]              o_rsp_pwr,
  output logic                          o_rsp_err,
  output logic                          o_err_sticky,
  output logic [1:0]                    o_state,
  output logic                          o_grant_ch
);

  tuner_phy_ctrl_arb_state_e state_q, state_d;
  tuner_ctrl_ch_e            ch_q, ch_d, rr_ptr_q, rr_ptr_d, gnt_ch;
  logic [NUM_CH-1:0]         gnt;
  logic                      clamp_q, clamp_d;
  logic                      armed_q, armed_d;
  logic [CNT_W-1:0]          settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0]          wait_cnt_q, wait_cnt_d;
  logic [CNT_W:0]            wait_next;
  logic [CODE_W-1:0]         tune_code_q, tune_code_d;
  logic                      tune_valid_q, tune_valid_d;
  logic                      pwr_req_q, pwr_req_d;
  logic [NUM_CH-1:0]         rsp_valid_q, rsp_valid_d;
  logic [CODE_W-1:0]         rsp_code_q, rsp_code_d;
  logic [PWR_W-1:0]          rsp_pwr_q, rsp_pwr_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      err_sticky_q, err_sticky_d;
  logic [CODE_W-1:0]         req_code_sel;
  logic                      req_clamp;

  tuner_phy_ctrl_rr_arb #(.LOCK_PRIO(LOCK_PRIO)) u_arb (
    .i_req    (i_req_valid),
    .i_ptr    (rr_ptr_q),
    .o_gnt    (gnt),
    .o_gnt_ch (gnt_ch)
  );

  assign o_req_ready  = (state_q == ARB_CTRL_INIT) ? gnt : '0;
  assign req_code_sel = i_req_code[gnt_ch];
  assign req_clamp    = req_code_sel > i_code_max;
  // One extra bit so the wait counter never wraps before it meets the limit.
  assign wait_next    = {1'b0, wait_cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    rr_ptr_d     = rr_ptr_q;
    clamp_d      = clamp_q;
    armed_d      = armed_q;
    settle_cnt_d = settle_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    tune_code_d  = tune_code_q;
    tune_valid_d = 1'b0;
    pwr_req_d    = 1'b0;
    rsp_valid_d  = '0;
    rsp_code_d   = rsp_code_q;
    rsp_pwr_d    = rsp_pwr_q;
    rsp_err_d    = rsp_err_q;
    err_sticky_d = err_sticky_q;

    case (state_q)
      ARB_CTRL_INIT: begin
        if ((i_req_valid & gnt) != '0) begin
          ch_d         = gnt_ch;
          clamp_d      = req_clamp;
          tune_code_d  = req_clamp ? i_code_max : req_code_sel;
          tune_valid_d = 1'b1;
          state_d      = ARB_CTRL_TUNE;
        end
      end
      ARB_CTRL_TUNE: begin
        settle_cnt_d = i_settle_cyc;
        wait_cnt_d   = '0;
        armed_d      = 1'b0;
        pwr_req_d    = (i_settle_cyc == '0);
        state_d      = ARB_CTRL_SYNC;
      end
      ARB_CTRL_SYNC: begin
        if (!armed_q) begin
          if (settle_cnt_q != '0) begin
            settle_cnt_d = settle_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            pwr_req_d    = (settle_cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});
          end
          // Samples only count from the cycle after the request pulse.
          armed_d = pwr_req_q;
        end else if (i_pwr_valid || (wait_next >= {1'b0, i_timeout_cyc})) begin
          rsp_valid_d  = NUM_CH'(1) << ch_q;
          rsp_code_d   = tune_code_q;
          rsp_pwr_d    = i_pwr_valid ? i_pwr : '0;
          rsp_err_d    = clamp_q | ~i_pwr_valid;
          err_sticky_d = err_sticky_q | clamp_q | ~i_pwr_valid;
          armed_d      = 1'b0;
          state_d      = ARB_CTRL_COMMIT;
        end else begin
          wait_cnt_d = wait_next[CNT_W-1:0];
        end
      end
      ARB_CTRL_COMMIT: begin
        rr_ptr_d = other_ch(ch_q);
        state_d  = ARB_CTRL_INIT;
      end
      default: state_d = ARB_CTRL_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_CTRL_INIT;
      ch_q         <= CH_SEARCH;
      rr_ptr_q     <= CH_SEARCH;
      clamp_q      <= 1'b0;
      armed_q      <= 1'b0;
      settle_cnt_q <= '0;
      wait_cnt_q   <= '0;
      tune_code_q  <= '0;
      tune_valid_q <= 1'b0;
      pwr_req_q    <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_code_q   <= '0;
      rsp_pwr_q    <= '0;
      rsp_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
      state_q      <= state_d;
      ch_q         <= ch_d;
      rr_ptr_q     <= rr_ptr_d;
      clamp_q      <= clamp_d;
      armed_q      <= armed_d;
      settle_cnt_q <= settle_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      tune_code_q  <= tune_code_d;
      tune_valid_q <= tune_valid_d;
      pwr_req_q    <= pwr_req_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_code_q   <= rsp_code_d;
      rsp_pwr_q    <= rsp_pwr_d;
      rsp_err_q    <= rsp_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign o_tune_code  = tune_code_q;
  assign o_tune_valid = tune_valid_q;
  assign o_pwr_req    = pwr_req_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_code   = rsp_code_q;
  assign o_rsp_pwr    = rsp_pwr_q;
  assign o_rsp_err    = rsp_err_q;
  assign o_err_sticky = err_sticky_q;
  assign o_state      = state_q;
  assign o_grant_ch   = ch_q;

endmodule

// File: tb/tb_tuner_phy_ctrl_arbiter.sv
// Scoreboard bench: a priority instance driven transaction by transaction and a
// round-robin instance with both channels always requesting.
module tb_tuner_phy_ctrl_arbiter;
  import tuner_phy_pkg::*;

  localparam int CODE_W = 8;
  localparam int PWR_W  = 12;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]             i_req_valid = '0;
  logic [1:0]             o_req_ready;
  logic [1:0][CODE_W-1:0] i_req_code = '0;
  logic [CODE_W-1:0]      i_code_max = 8'hFF;
  logic [CNT_W-1:0]       i_settle_cyc = '0;
  logic [CNT_W-1:0]       i_timeout_cyc = 16'd10;
  logic [CODE_W-1:0]      o_tune_code;
  logic                   o_tune_valid, o_pwr_req;
  logic                   i_pwr_valid = 1'b0;
  logic [PWR_W-1:0]       i_pwr = '0;
  logic [1:0]             o_rsp_valid;
  logic [CODE_W-1:0]      o_rsp_code;
  logic [PWR_W-1:0]       o_rsp_pwr;
  logic                   o_rsp_err, o_err_sticky;
  logic [1:0]             o_state;
  logic                   o_grant_ch;

  logic [1:0]             rr_req_ready, rr_rsp_valid, rr_state;
  logic [CODE_W-1:0]      rr_tune_code, rr_rsp_code;
  logic                   rr_tune_valid, rr_pwr_req, rr_rsp_err, rr_err_sticky, rr_grant_ch;
  logic [PWR_W-1:0]       rr_rsp_pwr;
  logic [1:0][CODE_W-1:0] rr_req_code = {8'h11, 8'h22};

  tuner_phy_ctrl_arbiter #(.CODE_W(CODE_W), .PWR_W(PWR_W), .CNT_W(CNT_W), .LOCK_PRIO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_code(i_req_code), .i_code_max(i_code_max), .i_settle_cyc(i_settle_cyc),
    .i_timeout_cyc(i_timeout_cyc), .o_tune_code(o_tune_code), .o_tune_valid(o_tune_valid),
    .o_pwr_req(o_pwr_req), .i_pwr_valid(i_pwr_valid), .i_pwr(i_pwr), .o_rsp_valid(o_rsp_valid),
    .o_rsp_code(o_rsp_code), .o_rsp_pwr(o_rsp_pwr), .o_rsp_err(o_rsp_err),
    .o_err_sticky(o_err_sticky), .o_state(o_state), .o_grant_ch(o_grant_ch)
  );

  tuner_phy_ctrl_arbiter #(.CODE_W(CODE_W), .PWR_W(PWR_W), .CNT_W(CNT_W), .LOCK_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .i_req_valid(2'b11), .o_req_ready(rr_req_ready),
    .i_req_code(rr_req_code), .i_code_max(8'hFF), .i_settle_cyc(16'd0),
    .i_timeout_cyc(16'd8), .o_tune_code(rr_tune_code), .o_tune_valid(rr_tune_valid),
    .o_pwr_req(rr_pwr_req), .i_pwr_valid(1'b1), .i_pwr(12'h0AA), .o_rsp_valid(rr_rsp_valid),
    .o_rsp_code(rr_rsp_code), .o_rsp_pwr(rr_rsp_pwr), .o_rsp_err(rr_rsp_err),
    .o_err_sticky(rr_err_sticky), .o_state(rr_state), .o_grant_ch(rr_grant_ch)
  );

  typedef struct {
    logic [1:0]        vld;
    logic [CODE_W-1:0] code;
    logic [PWR_W-1:0]  pwr;
    logic              err;
  } rsp_t;

  rsp_t sb_q[$];
  rsp_t mon_e;
  int   total = 0;
  int   bad = 0;
  logic sticky_m = 1'b0;
  int   rr_n = 0;
  logic rr_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && o_rsp_valid != 2'b00) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexp", 32'(o_rsp_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        sticky_m = sticky_m | mon_e.err;
        check("rsp_valid", 32'(o_rsp_valid), 32'(mon_e.vld));
        check("rsp_code", 32'(o_rsp_code), 32'(mon_e.code));
        check("rsp_pwr", 32'(o_rsp_pwr), 32'(mon_e.pwr));
        check("rsp_err", 32'(o_rsp_err), 32'(mon_e.err));
        check("err_sticky", 32'(o_err_sticky), 32'(sticky_m));
      end
    end
  end

  // Round-robin instance with both channels always valid must alternate S, L, S, ...
  always @(negedge clk) begin
    if (rst_n && rr_tune_valid && rr_n < 6) begin
      check("rr_grant", 32'(rr_grant_ch), 32'(rr_exp));
      check("rr_rsp_ch", 32'(rr_rsp_valid), 32'd0);
      rr_exp = ~rr_exp;
      rr_n++;
    end
  end

  // k = wait cycle (1-based, after the o_pwr_req cycle) carrying the sample; 0 = never.
  task automatic do_req(input logic ch, input logic [CODE_W-1:0] code, input int settle,
                        input int tmo, input int k, input logic [PWR_W-1:0] pwr, input bit stray);
    rsp_t e;
    int n;
    logic clamp;
    logic [CODE_W-1:0] ce;
    i_settle_cyc   = CNT_W'(settle);
    i_timeout_cyc  = CNT_W'(tmo);
    i_req_code[ch] = code;
    i_req_valid[ch] = 1'b1;
    #1;
    n = 0;
    while (!o_req_ready[ch] && n < 50) begin
      tick();
      n++;
    end
    check("req_ready", 32'(o_req_ready), 32'(2'b01 << ch));
    clamp = code > i_code_max;
    ce    = clamp ? i_code_max : code;
    e.vld  = 2'b01 << ch;
    e.code = ce;
    e.pwr  = (k > 0) ? pwr : '0;
    e.err  = clamp || (k == 0);
    sb_q.push_back(e);
    tick();
    i_req_valid[ch] = 1'b0;
    check("tune_valid", 32'(o_tune_valid), 32'd1);
    check("tune_code", 32'(o_tune_code), 32'(ce));
    check("grant_ch", 32'(o_grant_ch), 32'(ch));
    check("state_tune", 32'(o_state), 32'(ARB_CTRL_TUNE));
    if (stray) begin
      i_pwr_valid = 1'b1;
      i_pwr       = 12'hBAD;
    end
    tick();
    i_pwr_valid = 1'b0;
    n = 1;
    while (!o_pwr_req && n < 100) begin
      tick();
      n++;
    end
    check("pwr_req_lat", 32'(n), 32'(1 + settle));
    for (int j = 1; j <= ((k > 0) ? k : tmo); j++) begin
      tick();
      check("pwr_req_pulse", 32'(o_pwr_req), 32'd0);
      if (j == k) begin
        i_pwr_valid = 1'b1;
        i_pwr       = pwr;
      end
    end
    tick();
    i_pwr_valid = 1'b0;
    check("state_commit", 32'(o_state), 32'(ARB_CTRL_COMMIT));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(o_state), 32'(ARB_CTRL_INIT));
    check("rst_tune_code", 32'(o_tune_code), 32'd0);
    check("rst_outs", {26'd0, o_tune_valid, o_pwr_req, o_rsp_valid, o_err_sticky, o_grant_ch}, 32'd0);
    check("rst_ready", 32'(o_req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic SEARCH transaction.
    do_req(1'b0, 8'h40, 3, 10, 2, 12'h123, 1'b0);

    // Simultaneous requests: LOCK first, SEARCH waits in INIT then follows.
    i_req_code[0]  = 8'h22;
    i_req_valid[0] = 1'b1;
    do_req(1'b1, 8'h55, 1, 10, 1, 12'h456, 1'b0);
    do_req(1'b0, 8'h22, 1, 10, 3, 12'h789, 1'b0);

    // Code above limit is clamped and flagged.
    i_code_max = 8'hC0;
    do_req(1'b0, 8'hF0, 2, 10, 1, 12'h0F0, 1'b0);
    i_code_max = 8'hC0;
    do_req(1'b1, 8'hC0, 0, 10, 1, 12'h0C0, 1'b0);
    i_code_max = 8'hFF;

    // Timeout with no sample, then a sample landing on the last wait cycle.
    do_req(1'b1, 8'h31, 2, 4, 0, 12'h000, 1'b0);
    do_req(1'b0, 8'h32, 2, 4, 4, 12'h3A5, 1'b0);

    // Zero settle with a stray sample during TUNE.
    do_req(1'b0, 8'h77, 0, 6, 2, 12'h5C3, 1'b1);

    // Reset in the middle of SYNC: back to INIT with nothing emitted.
    i_settle_cyc   = 16'd10;
    i_req_code[1]  = 8'h66;
    i_req_valid[1] = 1'b1;
    #1;
    check("pre_rst_ready", 32'(o_req_ready), 32'd2);
    tick();
    i_req_valid[1] = 1'b0;
    repeat (3) tick();
    check("mid_sync_state", 32'(o_state), 32'(ARB_CTRL_SYNC));
    #2;
    rst_n = 1'b0;
    #1;
    sticky_m = 1'b0;
    check("rst_mid_state", 32'(o_state), 32'(ARB_CTRL_INIT));
    check("rst_mid_code", 32'(o_tune_code), 32'd0);
    check("rst_mid_outs", {26'd0, o_tune_valid, o_pwr_req, o_rsp_valid, o_err_sticky, o_grant_ch}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_req(1'b1, 8'h12, 1, 10, 2, 12'h321, 1'b0);

    repeat (3) tick();
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("rr_count", 32'(rr_n), 32'd6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
